// File: rtl/cr_huf_comp_ph_loader_pkg.sv
// Shared constants, FSM encoding and write-port payload for the predefined Huffman table loader.
// Optional build macro: CR_HUF_COMP_PH_LOADER_LAST_CHK_EN (see cr_huf_comp_ph_loader.sv).
package cr_huf_comp_ph_loader_pkg;

  localparam int unsigned NUM_TABLES = 10;
  localparam int unsigned LONG_DEPTH = 22;
  localparam int unsigned SHRT_DEPTH = 48;
  localparam int unsigned DATA_WIDTH = 60;
  localparam int unsigned MEM_ID_W   = 4;
  localparam int unsigned ADDR_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FREE,
    ST_LOAD,
    ST_DONE
  } e_ph_ld_state;

  typedef struct packed {
    logic                  wr;
    logic [MEM_ID_W-1:0]   mem_id;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } s_sm_predet_mem_intf;

  // Address of the final word for a table of the given type (0 = long, 1 = short).
  function automatic logic [ADDR_W-1:0] depth_m1(input logic is_shrt);
    return is_shrt ? ADDR_W'(SHRT_DEPTH - 1) : ADDR_W'(LONG_DEPTH - 1);
  endfunction

endpackage

// File: rtl/cr_huf_comp_ph_loader_if.sv
// Load request / table word stream between the table source (master) and the loader (slave).
interface cr_huf_comp_ph_loader_if;
  import cr_huf_comp_ph_loader_pkg::*;

  logic                  ld_req;
  logic                  ld_type;
  logic [MEM_ID_W-1:0]   ld_mem_id;
  logic                  ld_ack;
  logic                  ld_data_val;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_data_last;
  logic                  ld_data_rdy;

  modport master (
    output ld_req, ld_type, ld_mem_id, ld_data_val, ld_data, ld_data_last,
    input  ld_ack, ld_data_rdy
  );

  modport slave (
    input  ld_req, ld_type, ld_mem_id, ld_data_val, ld_data, ld_data_last,
    output ld_ack, ld_data_rdy
  );

endinterface

// File: rtl/cr_huf_comp_ph_loader.sv
// Writes predefined Huffman tables into the long/short predet memories and tracks which slots are fully loaded.
// Define CR_HUF_COMP_PH_LOADER_LAST_CHK_EN to cross-check ld_data_last against the word count.
module cr_huf_comp_ph_loader
  import cr_huf_comp_ph_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  cr_huf_comp_ph_loader_if.slave  ld,
  input  logic [NUM_TABLES-1:0]   mem_in_use,
  output s_sm_predet_mem_intf     sm_predet_mem_long_intf,
  output s_sm_predet_mem_intf     sm_predet_mem_shrt_intf,
  output logic [NUM_TABLES-1:0]   tbl_long_valid,
  output logic [NUM_TABLES-1:0]   tbl_shrt_valid,
  output logic                    ld_done,
  output logic                    ld_err
);

  e_ph_ld_state          state_q, state_nxt;
  logic                  type_q, type_nxt;
  logic [MEM_ID_W-1:0]   id_q, id_nxt;
  logic [ADDR_W-1:0]     cnt_q, cnt_nxt;
  logic                  ack_q, ack_nxt;
  logic                  rdy_q, rdy_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;
  s_sm_predet_mem_intf   long_wr_q, long_wr_nxt;
  s_sm_predet_mem_intf   shrt_wr_q, shrt_wr_nxt;
  logic [NUM_TABLES-1:0] long_valid_q, long_valid_nxt;
  logic [NUM_TABLES-1:0] shrt_valid_q, shrt_valid_nxt;

  logic                  beat;
  logic                  last_beat;
  s_sm_predet_mem_intf   wr_word;

`ifndef CR_HUF_COMP_PH_LOADER_LAST_CHK_EN
  logic unused_last;
  assign unused_last = ld.ld_data_last;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state_q;
    type_nxt       = type_q;
    id_nxt         = id_q;
    cnt_nxt        = cnt_q;
    ack_nxt        = 1'b0;
    rdy_nxt        = rdy_q;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    long_wr_nxt    = '0;
    shrt_wr_nxt    = '0;
    long_valid_nxt = long_valid_q;
    shrt_valid_nxt = shrt_valid_q;
    beat           = ld.ld_data_val & rdy_q;
    last_beat      = (cnt_q == depth_m1(type_q));
    wr_word        = '{wr: 1'b1, mem_id: id_q, addr: cnt_q, data: ld.ld_data};

    unique case (state_q)
      ST_IDLE: begin
        if (ld.ld_req) begin
          ack_nxt = 1'b1;
          if (ld.ld_mem_id < MEM_ID_W'(NUM_TABLES)) begin
            type_nxt  = ld.ld_type;
            id_nxt    = ld.ld_mem_id;
            state_nxt = ST_WAIT_FREE;
            // Invalidate up front so no new sequence can pick a half-written table
            if (ld.ld_type) shrt_valid_nxt[ld.ld_mem_id] = 1'b0;
            else            long_valid_nxt[ld.ld_mem_id] = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ST_WAIT_FREE: begin
        if (!mem_in_use[id_q]) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
          rdy_nxt   = 1'b1;
        end
      end

      ST_LOAD: begin
        if (beat) begin
          if (type_q) shrt_wr_nxt = wr_word;
          else        long_wr_nxt = wr_word;
          if (!last_beat) cnt_nxt = cnt_q + ADDR_W'(1);
`ifdef CR_HUF_COMP_PH_LOADER_LAST_CHK_EN
          if (ld.ld_data_last != last_beat) begin
            err_nxt   = 1'b1;
            rdy_nxt   = 1'b0;
            state_nxt = ST_IDLE;
          end else if (last_beat) begin
            rdy_nxt   = 1'b0;
            state_nxt = ST_DONE;
          end
`else
          if (last_beat) begin
            rdy_nxt   = 1'b0;
            state_nxt = ST_DONE;
          end
`endif
        end
      end

      ST_DONE: begin
        if (type_q) shrt_valid_nxt[id_q] = 1'b1;
        else        long_valid_nxt[id_q] = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      type_q       <= 1'b0;
      id_q         <= '0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      rdy_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      long_wr_q    <= '0;
      shrt_wr_q    <= '0;
      long_valid_q <= '0;
      shrt_valid_q <= '0;
    end else begin
      state_q      <= state_nxt;
      type_q       <= type_nxt;
      id_q         <= id_nxt;
      cnt_q        <= cnt_nxt;
      ack_q        <= ack_nxt;
      rdy_q        <= rdy_nxt;
      done_q       <= done_nxt;
      err_q        <= err_nxt;
      long_wr_q    <= long_wr_nxt;
      shrt_wr_q    <= shrt_wr_nxt;
      long_valid_q <= long_valid_nxt;
      shrt_valid_q <= shrt_valid_nxt;
    end
  end

  assign ld.ld_ack                = ack_q;
  assign ld.ld_data_rdy           = rdy_q;
  assign ld_done                  = done_q;
  assign ld_err                   = err_q;
  assign sm_predet_mem_long_intf  = long_wr_q;
  assign sm_predet_mem_shrt_intf  = shrt_wr_q;
  assign tbl_long_valid           = long_valid_q;
  assign tbl_shrt_valid           = shrt_valid_q;

endmodule

// File: tb/tb_cr_huf_comp_ph_loader.sv
// Directed bench for cr_huf_comp_ph_loader: long/short loads, busy hold-off, bad id, gapped reload, mid-load reset.
module tb_cr_huf_comp_ph_loader;
  import cr_huf_comp_ph_loader_pkg::*;

  localparam int unsigned CW = 72;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_TABLES-1:0] mem_in_use;
  s_sm_predet_mem_intf   long_w;
  s_sm_predet_mem_intf   shrt_w;
  logic [NUM_TABLES-1:0] long_valid;
  logic [NUM_TABLES-1:0] shrt_valid;
  logic                  ld_done;
  logic                  ld_err;

  int n_total = 0;
  int n_bad   = 0;

  // Write monitor bookkeeping
  int              long_idx = 0, shrt_idx = 0;
  int              long_total = 0, shrt_total = 0;
  int              done_cnt = 0, err_cnt = 0;
  logic [3:0]      exp_id = '0;
  logic [59:0]     exp_base = '0;
  int              snap_long, snap_shrt;

  cr_huf_comp_ph_loader_if lif ();

  cr_huf_comp_ph_loader dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ld                      (lif.slave),
    .mem_in_use              (mem_in_use),
    .sm_predet_mem_long_intf (long_w),
    .sm_predet_mem_shrt_intf (shrt_w),
    .tbl_long_valid          (long_valid),
    .tbl_shrt_valid          (shrt_valid),
    .ld_done                 (ld_done),
    .ld_err                  (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   CW'(lif.ld_ack),      CW'(0));
    check({tag, "_rdy"},   CW'(lif.ld_data_rdy), CW'(0));
    check({tag, "_done"},  CW'(ld_done),         CW'(0));
    check({tag, "_err"},   CW'(ld_err),          CW'(0));
    check({tag, "_lval"},  CW'(long_valid),      CW'(0));
    check({tag, "_sval"},  CW'(shrt_valid),      CW'(0));
    check({tag, "_lwr"},   CW'(long_w),          CW'(0));
    check({tag, "_swr"},   CW'(shrt_w),          CW'(0));
  endtask

  task automatic do_req(input logic t, input logic [3:0] id);
    lif.ld_req    = 1'b1;
    lif.ld_type   = t;
    lif.ld_mem_id = id;
    step();
    check("ack", CW'(lif.ld_ack), CW'(1));
    lif.ld_req    = 1'b0;
  endtask

  // Offer n words (data = base + beat) with gap idle cycles before each; bounded wait on rdy
  task automatic send_table(input int n, input int gap, input logic [59:0] base, input int last_at);
    int t;
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) begin
        lif.ld_data_val = 1'b0;
        step();
      end
      lif.ld_data_val  = 1'b1;
      lif.ld_data      = base + 60'(b);
      lif.ld_data_last = (b == last_at);
      t = 0;
      while (!lif.ld_data_rdy && t < 64) begin
        step();
        t++;
      end
      if (!lif.ld_data_rdy) begin
        check("rdy_timeout", CW'(lif.ld_data_rdy), CW'(1));
        lif.ld_data_val = 1'b0;
        return;
      end
      step();
    end
    lif.ld_data_val  = 1'b0;
    lif.ld_data_last = 1'b0;
  endtask

  // Every write strobe must carry the next sequential address and expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (long_w.wr) begin
        check("long_addr", CW'(long_w.addr),   CW'(long_idx));
        check("long_id",   CW'(long_w.mem_id), CW'(exp_id));
        check("long_data", CW'(long_w.data),   CW'(exp_base + 60'(long_idx)));
        long_idx++;
        long_total++;
      end
      if (shrt_w.wr) begin
        check("shrt_addr", CW'(shrt_w.addr),   CW'(shrt_idx));
        check("shrt_id",   CW'(shrt_w.mem_id), CW'(exp_id));
        check("shrt_data", CW'(shrt_w.data),   CW'(exp_base + 60'(shrt_idx)));
        shrt_idx++;
        shrt_total++;
      end
      if (ld_done) done_cnt++;
      if (ld_err)  err_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    mem_in_use       = '0;
    lif.ld_req       = 1'b0;
    lif.ld_type      = 1'b0;
    lif.ld_mem_id    = '0;
    lif.ld_data_val  = 1'b0;
    lif.ld_data      = '0;
    lif.ld_data_last = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Long table 3, continuous beats, data = beat index
    exp_id = 4'd3; exp_base = 60'h0; long_idx = 0;
    do_req(1'b0, 4'd3);
    check("t1_rdy_wait", CW'(lif.ld_data_rdy), CW'(0));
    send_table(22, 0, 60'h0, 21);
    check("t1_lval_pre", CW'(long_valid), CW'(0));
    step();
    check("t1_lval", CW'(long_valid), CW'(10'h008));
    check("t1_done", CW'(ld_done),    CW'(1));
    step();
    check("t1_done_off", CW'(ld_done),    CW'(0));
    check("t1_nlong",    CW'(long_total), CW'(22));
    check("t1_nshrt",    CW'(shrt_total), CW'(0));
    check("t1_ndone",    CW'(done_cnt),   CW'(1));

    // Short table 9, held off by mem_in_use for 5 cycles
    exp_id = 4'd9; exp_base = 60'h100; shrt_idx = 0;
    mem_in_use = 10'h200;
    do_req(1'b1, 4'd9);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_rdy_busy", CW'(lif.ld_data_rdy), CW'(0));
    end
    mem_in_use = '0;
    send_table(48, 0, 60'h100, 47);
    check("t2_sval_pre", CW'(shrt_valid), CW'(0));
    step();
    check("t2_sval", CW'(shrt_valid), CW'(10'h200));
    check("t2_lval", CW'(long_valid), CW'(10'h008));
    check("t2_done", CW'(ld_done),    CW'(1));
    step();
    check("t2_nshrt", CW'(shrt_total), CW'(48));
    check("t2_ndone", CW'(done_cnt),   CW'(2));

    // Out-of-range mem_id 12
    snap_long = long_total; snap_shrt = shrt_total;
    do_req(1'b0, 4'd12);
    check("t3_err",     CW'(ld_err),          CW'(1));
    step();
    check("t3_ack_off", CW'(lif.ld_ack),      CW'(0));
    check("t3_err_off", CW'(ld_err),          CW'(0));
    check("t3_rdy",     CW'(lif.ld_data_rdy), CW'(0));
    step();
    check("t3_rdy2",    CW'(lif.ld_data_rdy), CW'(0));
    check("t3_lval",    CW'(long_valid),      CW'(10'h008));
    check("t3_sval",    CW'(shrt_valid),      CW'(10'h200));
    check("t3_nlong",   CW'(long_total),      CW'(snap_long));
    check("t3_nshrt",   CW'(shrt_total),      CW'(snap_shrt));
    check("t3_nerr",    CW'(err_cnt),         CW'(1));

    // Load long 0, then reload it with 1-in-3 gapped data
    exp_id = 4'd0; exp_base = 60'h200; long_idx = 0;
    do_req(1'b0, 4'd0);
    send_table(22, 0, 60'h200, 21);
    step();
    check("t4_lval_first", CW'(long_valid), CW'(10'h009));
    step();
    snap_long = long_total;
    exp_base = 60'h300; long_idx = 0;
    do_req(1'b0, 4'd0);
    check("t4_lval_drop", CW'(long_valid), CW'(10'h008));
    send_table(22, 2, 60'h300, 21);
    check("t4_lval_pre",  CW'(long_valid), CW'(10'h008));
    step();
    check("t4_lval",      CW'(long_valid), CW'(10'h009));
    check("t4_done",      CW'(ld_done),    CW'(1));
    step();
    check("t4_nlong",     CW'(long_total), CW'(snap_long + 22));

    // Reset after 10 beats of a short load, then reload the same id
    exp_id = 4'd2; exp_base = 60'h400; shrt_idx = 0;
    do_req(1'b1, 4'd2);
    send_table(10, 0, 60'h400, 47);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    rst_n = 1'b1;
    step();
    exp_base = 60'h500; shrt_idx = 0; snap_shrt = shrt_total;
    do_req(1'b1, 4'd2);
    send_table(48, 0, 60'h500, 47);
    step();
    check("t5_sval",  CW'(shrt_valid), CW'(10'h004));
    check("t5_lval",  CW'(long_valid), CW'(10'h000));
    check("t5_done",  CW'(ld_done),    CW'(1));
    step();
    check("t5_nshrt", CW'(shrt_total), CW'(snap_shrt + 48));

`ifdef CR_HUF_COMP_PH_LOADER_LAST_CHK_EN
    // Early last on beat 15 of long 4 aborts the load
    exp_id = 4'd4; exp_base = 60'h600; long_idx = 0;
    do_req(1'b0, 4'd4);
    send_table(16, 0, 60'h600, 15);
    check("t6_err",     CW'(ld_err),          CW'(1));
    check("t6_rdy",     CW'(lif.ld_data_rdy), CW'(0));
    check("t6_done",    CW'(ld_done),         CW'(0));
    check("t6_wr",      CW'(long_w.wr),       CW'(1));
    step();
    check("t6_err_off", CW'(ld_err),          CW'(0));
    check("t6_lval",    CW'(long_valid),      CW'(10'h000));
    // Missing last on the final beat also aborts
    exp_base = 60'h700; long_idx = 0;
    do_req(1'b0, 4'd4);
    send_table(22, 0, 60'h700, 99);
    check("t7_err",     CW'(ld_err),          CW'(1));
    check("t7_done",    CW'(ld_done),         CW'(0));
    step();
    check("t7_lval",    CW'(long_valid),      CW'(10'h000));
    check("t7_done2",   CW'(ld_done),         CW'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
